// File: rtl/alu_staged.sv
// rtl/alu_staged.sv - staged ALU with split operand capture, timeout and multi-cycle multiply
module alu_staged #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ce_i,
  input  logic [1:0]      inp_valid_i,
  input  logic [DW-1:0]   opa_i,
  input  logic [DW-1:0]   opb_i,
  input  logic            cin_i,
  input  logic            mode_i,
  input  logic [CW-1:0]   cmd_i,
  output logic            in_ready_o,
  input  logic            out_ready_i,
  output logic            res_valid_o,
  output logic [2*DW-1:0] res_o,
  output logic            cout_o,
  output logic            oflow_o,
  output logic            g_o,
  output logic            e_o,
  output logic            l_o,
  output logic            err_o
);

  localparam int LW = $clog2(DW);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_A, S_WAIT_B, S_EXEC, S_MUL, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              mcnt_q, mcnt_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic              mode_q, mode_d, cin_q, cin_d;
  logic              valid_q, valid_d;
  logic [2*DW-1:0]   res_q, res_d;
  logic              cout_q, cout_d, oflow_q, oflow_d;
  logic              g_q, g_d, e_q, e_d, l_q, l_d, err_q, err_d;

  // ALU datapath signals, all derived from the captured operands
  logic [DW:0]       a_x, b_x, c_x, t, ax1, bx1;
  logic [DW-1:0]     lres, ash;
  logic [LW-1:0]     sh;
  logic [2*DW-1:0]   dbl;
  logic [2*DW+1:0]   prod9;
  logic [2*DW-1:0]   prod10;
  logic [2*DW-1:0]   alu_res;
  logic              alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err, is_mul;

  assign a_x    = {1'b0, a_q};
  assign b_x    = {1'b0, b_q};
  assign c_x    = {{DW{1'b0}}, cin_q};
  assign ax1    = a_x + (DW+1)'(1);
  assign bx1    = b_x + (DW+1)'(1);
  assign ash    = {a_q[DW-2:0], 1'b0};
  assign prod9  = {{(DW+1){1'b0}}, ax1} * {{(DW+1){1'b0}}, bx1};
  assign prod10 = {{DW{1'b0}}, ash} * {{DW{1'b0}}, b_q};
  assign sh     = b_q[LW-1:0];
  assign is_mul = mode_q && (cmd_q == CW'(9) || cmd_q == CW'(10));

  // Result and flag computation for the captured command
  always_comb begin
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_oflow = 1'b0;
    alu_g     = 1'b0;
    alu_e     = 1'b0;
    alu_l     = 1'b0;
    alu_err   = 1'b0;
    t         = '0;
    lres      = '0;
    dbl       = '0;
    if (mode_q) begin
      case (int'(cmd_q))
        0: begin t = a_x + b_x;         alu_res = {{(DW-1){1'b0}}, t}; alu_cout = t[DW]; end
        1: begin t = a_x - b_x;         alu_res = {{DW{1'b0}}, t[DW-1:0]}; alu_oflow = (a_q < b_q); end
        2: begin t = a_x + b_x + c_x;   alu_res = {{(DW-1){1'b0}}, t}; alu_cout = t[DW]; end
        3: begin t = a_x - b_x - c_x;   alu_res = {{DW{1'b0}}, t[DW-1:0]}; alu_oflow = (a_x < (b_x + c_x)); end
        4: begin t = ax1;               alu_res = {{(DW-1){1'b0}}, t}; alu_cout = t[DW]; end
        5: begin t = a_x - (DW+1)'(1);  alu_res = {{DW{1'b0}}, t[DW-1:0]}; alu_oflow = (a_q == '0); end
        6: begin t = bx1;               alu_res = {{(DW-1){1'b0}}, t}; alu_cout = t[DW]; end
        7: begin t = b_x - (DW+1)'(1);  alu_res = {{DW{1'b0}}, t[DW-1:0]}; alu_oflow = (b_q == '0); end
        8: begin alu_g = (a_q > b_q); alu_e = (a_q == b_q); alu_l = (a_q < b_q); end
        9:  alu_res = prod9[2*DW-1:0];
        10: alu_res = prod10;
        default: alu_err = 1'b1;
      endcase
    end else begin
      case (int'(cmd_q))
        0:  lres = a_q & b_q;
        1:  lres = ~(a_q & b_q);
        2:  lres = a_q | b_q;
        3:  lres = ~(a_q | b_q);
        4:  lres = a_q ^ b_q;
        5:  lres = ~(a_q ^ b_q);
        6:  lres = ~a_q;
        7:  lres = ~b_q;
        8:  lres = a_q >> 1;
        9:  lres = a_q << 1;
        10: lres = b_q >> 1;
        11: lres = b_q << 1;
        12: begin dbl = {a_q, a_q} << sh; lres = dbl[2*DW-1:DW]; alu_err = |(b_q >> LW); end
        13: begin dbl = {a_q, a_q} >> sh; lres = dbl[DW-1:0];    alu_err = |(b_q >> LW); end
        default: alu_err = 1'b1;
      endcase
      alu_res = {{DW{1'b0}}, lres};
    end
  end

  // State register; everything freezes while ce_i is low, reset wins regardless
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcnt_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (ce_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      err_q   <= err_d;
    end
  end

  // Next-state: operand capture, wait timeout, execute, multiply delay, result hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (inp_valid_i != 2'b00) begin
          cmd_d  = cmd_i;
          mode_d = mode_i;
          cin_d  = cin_i;
          cnt_d  = '0;
          if (inp_valid_i[0]) a_d = opa_i;
          if (inp_valid_i[1]) b_d = opb_i;
          case (inp_valid_i)
            2'b11:   state_d = S_EXEC;
            2'b01:   state_d = S_WAIT_B;
            default: state_d = S_WAIT_A;
          endcase
        end
      end
      S_WAIT_A, S_WAIT_B: begin
        if ((state_q == S_WAIT_B && inp_valid_i[1]) || (state_q == S_WAIT_A && inp_valid_i[0])) begin
          if (inp_valid_i[0]) a_d = opa_i;
          if (inp_valid_i[1]) b_d = opb_i;
          state_d = S_EXEC;
        end else if (inp_valid_i != 2'b00) begin
          // the already-held operand came again: replace it and restart the wait
          if (inp_valid_i[0]) a_d = opa_i;
          if (inp_valid_i[1]) b_d = opb_i;
          cnt_d = '0;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = '0;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b0;
          l_d     = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (is_mul) begin
          state_d = S_MUL;
          mcnt_d  = 1'b0;
        end else begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = alu_res;
          cout_d  = alu_cout;
          oflow_d = alu_oflow;
          g_d     = alu_g;
          e_d     = alu_e;
          l_d     = alu_l;
          err_d   = alu_err;
        end
      end
      S_MUL: begin
        if (mcnt_q) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = alu_res;
          cout_d  = alu_cout;
          oflow_d = alu_oflow;
          g_d     = alu_g;
          e_d     = alu_e;
          l_d     = alu_l;
          err_d   = alu_err;
        end else begin
          mcnt_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          res_d   = '0;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b0;
          l_d     = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_WAIT_A) || (state_q == S_WAIT_B);
  assign res_valid_o = valid_q;
  assign res_o       = res_q;
  assign cout_o      = cout_q;
  assign oflow_o     = oflow_q;
  assign g_o         = g_q;
  assign e_o         = e_q;
  assign l_o         = l_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_alu_staged.sv
// tb/tb_alu_staged.sv - directed self-checking bench for alu_staged
module tb_alu_staged;

  logic        clk = 1'b0;
  logic        rst, ce, cin, mode, out_ready;
  logic [1:0]  inp_valid;
  logic [7:0]  opa, opb;
  logic [3:0]  cmd;
  logic        in_ready, res_valid, cout, oflow, g, e, l, err;
  logic [15:0] res;
  int          total = 0;
  int          bad = 0;

  alu_staged #(.DW(8), .CW(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .inp_valid_i(inp_valid),
    .opa_i(opa), .opb_i(opb), .cin_i(cin), .mode_i(mode), .cmd_i(cmd),
    .in_ready_o(in_ready), .out_ready_i(out_ready), .res_valid_o(res_valid),
    .res_o(res), .cout_o(cout), .oflow_o(oflow), .g_o(g), .e_o(e), .l_o(l), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {valid, cout, oflow, g, e, l, err}
  function automatic logic [6:0] flags();
    return {res_valid, cout, oflow, g, e, l, err};
  endfunction

  task automatic run_op(input logic m, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
    mode = m; cmd = c; opa = a; opb = b; cin = ci; inp_valid = 2'b11;
    step();
    inp_valid = 2'b00;
    step();
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; cin = 1'b0; mode = 1'b0; out_ready = 1'b0;
    inp_valid = 2'b00; opa = '0; opb = '0; cmd = '0;
    step();
    step();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_flags", flags(), 7'b0);
    chk("reset_res", res, 0);
    rst = 1'b0; ce = 1'b1;

    // 200+100 with carry out, one cycle after capture
    run_op(1, 0, 200, 100, 0);
    chk("add_res", res, 300);
    chk("add_flags", flags(), 7'b1100000);
    release_res();
    chk("release_flags", flags(), 7'b0);
    chk("release_res", res, 0);
    chk("release_in_ready", in_ready, 1);

    run_op(1, 1, 5, 7, 0);
    chk("sub_res", res, 16'h00FE);
    chk("sub_flags", flags(), 7'b1010000);
    release_res();
    run_op(1, 3, 10, 9, 1);
    chk("subc_res", res, 0);
    chk("subc_flags", flags(), 7'b1000000);
    release_res();
    run_op(1, 4, 255, 0, 0);
    chk("inca_max_res", res, 256);
    chk("inca_max_flags", flags(), 7'b1100000);
    release_res();
    run_op(1, 5, 0, 0, 0);
    chk("deca_zero_res", res, 255);
    chk("deca_zero_flags", flags(), 7'b1010000);
    release_res();
    run_op(1, 8, 3, 3, 0);
    chk("cmp_eq", {res, flags()}, {16'd0, 7'b1000100});
    release_res();
    run_op(1, 8, 9, 3, 0);
    chk("cmp_gt", {res, flags()}, {16'd0, 7'b1001000});
    release_res();
    run_op(0, 1, 8'hF0, 8'h3C, 0);
    chk("nand_res", res, 16'h00CF);
    chk("nand_flags", flags(), 7'b1000000);
    release_res();
    run_op(0, 12, 8'h81, 8'h14, 0);
    chk("rotl_res", res, 16'h0018);
    chk("rotl_flags", flags(), 7'b1000001);
    release_res();
    run_op(0, 13, 8'h81, 8'h01, 0);
    chk("rotr_res", res, 16'h00C0);
    chk("rotr_flags", flags(), 7'b1000000);
    release_res();
    run_op(1, 15, 8'h12, 8'h34, 1);
    chk("undef_res", res, 0);
    chk("undef_flags", flags(), 7'b1000001);
    release_res();

    // split capture: A, three idle cycles, then B; (5+1)*(7+1)=48 three cycles later
    mode = 1; cmd = 9; opa = 5; inp_valid = 2'b01;
    step();
    inp_valid = 2'b00;
    step(); step(); step();
    chk("wait_in_ready", in_ready, 1);
    opb = 7; inp_valid = 2'b10;
    step();
    inp_valid = 2'b00;
    step();
    chk("mul_lat1", res_valid, 0);
    step();
    chk("mul_lat2", res_valid, 0);
    step();
    chk("mul_res", res, 48);
    chk("mul_flags", flags(), 7'b1000000);
    release_res();

    // (A<<1 within 8 bits)*B: 0x81 -> 0x02, times 3
    run_op(1, 10, 8'h81, 3, 0);
    step(); step();
    chk("mul10_res", res, 6);
    release_res();

    // timeout after 16 idle cycles, later OPB ignored
    mode = 1; cmd = 0; opa = 5; inp_valid = 2'b01;
    step();
    inp_valid = 2'b00;
    for (int i = 0; i < 15; i++) step();
    chk("timeout_not_yet", res_valid, 0);
    step();
    chk("timeout_flags", flags(), 7'b1000001);
    chk("timeout_res", res, 0);
    opb = 9; inp_valid = 2'b10;
    step();
    inp_valid = 2'b00;
    chk("timeout_hold_res", {res, flags()}, {16'd0, 7'b1000001});
    release_res();
    step(); step();
    chk("late_b_ignored", {res_valid, in_ready}, 2'b01);

    // re-arrival of A restarts the wait counter
    mode = 1; cmd = 0; opa = 1; inp_valid = 2'b01;
    step();
    inp_valid = 2'b00;
    for (int i = 0; i < 10; i++) step();
    opa = 4; inp_valid = 2'b01;
    step();
    inp_valid = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("rearrive_waiting", {res_valid, in_ready}, 2'b01);
    opb = 2; inp_valid = 2'b10;
    step();
    inp_valid = 2'b00;
    step();
    chk("rearrive_res", res, 6);
    release_res();

    // hold with back-pressure, new inputs ignored
    run_op(1, 0, 1, 2, 0);
    opa = 50; opb = 50; inp_valid = 2'b11;
    for (int i = 0; i < 5; i++) step();
    chk("hold_res", res, 3);
    chk("hold_ready", {res_valid, in_ready}, 2'b10);
    inp_valid = 2'b00;
    release_res();
    step(); step();
    chk("hold_input_ignored", {res_valid, res}, 17'd0);

    // clock enable low freezes capture
    ce = 0; mode = 1; cmd = 0; opa = 1; opb = 1; inp_valid = 2'b11;
    step();
    inp_valid = 2'b00;
    step();
    chk("ce_freeze", {res_valid, in_ready}, 2'b01);
    ce = 1; inp_valid = 2'b11;
    step();
    inp_valid = 2'b00;
    step();
    chk("ce_resume_res", {res_valid, res}, {1'b1, 16'd2});
    release_res();

    // reset during multiply aborts the result
    run_op(1, 9, 2, 3, 0);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mul_out", {res_valid, res, in_ready}, {1'b0, 16'd0, 1'b1});
    step(); step(); step();
    chk("rst_mul_no_result", flags(), 7'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
